// File: rtl/ram16k_dma_pkg.sv
// ram16k_dma_pkg
// Shared constants for the ram16k DMA engine: bus widths matching ram16k,
// FSM state encoding and transfer mode values.
package ram16k_dma_pkg;

  localparam int ADR_W  = 14;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/ram16k_dma_if.sv
// ram16k_dma_if
// Bundles the host control handshake and the ram16k bus seen by the DMA.
//   start/mode/src/dst/len/fill_value : host -> DMA request
//   busy/done                         : DMA -> host status
//   mem_adr/mem_data/mem_load         : DMA -> RAM
//   mem_out                           : RAM -> DMA (combinational read data)
// master = DMA engine side, slave = host + RAM side.
interface ram16k_dma_if;
  import ram16k_dma_pkg::*;

  logic              start;
  logic              mode;
  logic [ADR_W-1:0]  src;
  logic [ADR_W-1:0]  dst;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] fill_value;
  logic              busy;
  logic              done;
  logic [ADR_W-1:0]  mem_adr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_load;
  logic [DATA_W-1:0] mem_out;

  modport master (
    input  start, mode, src, dst, len, fill_value, mem_out,
    output busy, done, mem_adr, mem_data, mem_load
  );

  modport slave (
    output start, mode, src, dst, len, fill_value, mem_out,
    input  busy, done, mem_adr, mem_data, mem_load
  );

endinterface

// File: rtl/ram16k_dma.sv
// ram16k_dma
// Initiator engine for the ram16k port: ascending block copy (read src word,
// write it to dst) or block fill (write a constant), one word per pass.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ram16k_dma_if.master (control request, status, RAM bus)
//
// state    | meaning
// ST_IDLE  | waiting for start; all outputs 0
// ST_READ  | copy only: drive src_ptr, capture mem_out into buffer
// ST_WRITE | drive dst_ptr with buffer, mem_load = 1
// ST_DONE  | single-cycle done pulse, then back to idle
module ram16k_dma
  import ram16k_dma_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  ram16k_dma_if.master bus
);

  state_t            r_state;
  logic              r_mode;
  logic [ADR_W-1:0]  r_src_ptr;
  logic [ADR_W-1:0]  r_dst_ptr;
  logic [LEN_W-1:0]  r_remaining;
  logic [DATA_W-1:0] r_buf;

  logic              r_busy;
  logic              r_done;
  logic [ADR_W-1:0]  r_mem_adr;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_mem_load;

  logic [ADR_W-1:0]  w_dst_next;

  // Pointers wrap modulo 2^ADR_W by plain overflow.
  assign w_dst_next = r_dst_ptr + 1'b1;

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.mem_adr  = r_mem_adr;
  assign bus.mem_data = r_mem_data;
  assign bus.mem_load = r_mem_load;

  // Outputs are registered: every transition loads the output values that
  // belong to the state being entered, so they never follow the inputs
  // combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_COPY;
      r_src_ptr   <= '0;
      r_dst_ptr   <= '0;
      r_remaining <= '0;
      r_buf       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_mem_adr   <= '0;
      r_mem_data  <= '0;
      r_mem_load  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_mode      <= bus.mode;
            r_src_ptr   <= bus.src;
            r_dst_ptr   <= bus.dst;
            r_remaining <= bus.len;
            if (bus.mode == MODE_FILL) begin
              r_buf <= bus.fill_value;
            end
            if (bus.len == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else if (bus.mode == MODE_FILL) begin
              r_state    <= ST_WRITE;
              r_busy     <= 1'b1;
              r_mem_adr  <= bus.dst;
              r_mem_data <= bus.fill_value;
              r_mem_load <= 1'b1;
            end else begin
              r_state   <= ST_READ;
              r_busy    <= 1'b1;
              r_mem_adr <= bus.src;
            end
          end
        end

        ST_READ: begin
          r_buf      <= bus.mem_out;
          r_src_ptr  <= r_src_ptr + 1'b1;
          r_state    <= ST_WRITE;
          r_mem_adr  <= r_dst_ptr;
          r_mem_data <= bus.mem_out;
          r_mem_load <= 1'b1;
        end

        ST_WRITE: begin
          r_dst_ptr   <= w_dst_next;
          r_remaining <= r_remaining - 1'b1;
          if (r_remaining == LEN_W'(1)) begin
            r_state    <= ST_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_mem_adr  <= '0;
            r_mem_data <= '0;
            r_mem_load <= 1'b0;
          end else if (r_mode == MODE_FILL) begin
            r_mem_adr  <= w_dst_next;
            r_mem_data <= r_buf;
          end else begin
            // src_ptr was already advanced in the preceding READ.
            r_state    <= ST_READ;
            r_mem_adr  <= r_src_ptr;
            r_mem_data <= '0;
            r_mem_load <= 1'b0;
          end
        end

        ST_DONE: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_mem_adr  <= '0;
          r_mem_data <= '0;
          r_mem_load <= 1'b0;
        end

        default: begin
          r_state    <= ST_IDLE;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_mem_adr  <= '0;
          r_mem_data <= '0;
          r_mem_load <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram16k_dma.sv
// tb_ram16k_dma
// Bench for ram16k_dma: a 16K-word RAM responder, a transfer-level reference
// model that expands each request into its expected bus cycles, and one
// per-cycle compare process.
module tb_ram16k_dma;
  import ram16k_dma_pkg::*;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic              load;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;
  } exp_t;

  typedef struct packed {
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk;
  logic rst_n;

  ram16k_dma_if bus();

  ram16k_dma dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DATA_W-1:0] ram       [16384];
  logic [DATA_W-1:0] model_mem [16384];
  logic [DATA_W-1:0] tmp_mem   [16384];

  exp_t exq[$];
  wr_t  wq[$];

  int checks;
  int errors;
  int done_cnt;
  int busy_cnt;
  int load_cnt;

  logic              bd_init;
  logic              bd_we;
  logic [ADR_W-1:0]  bd_adr;
  logic [DATA_W-1:0] bd_data;

  function automatic logic [DATA_W-1:0] pat(int i);
    return 16'(i * 37) ^ 16'h5a0f;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM responder: combinational read, write on the rising edge.
  assign bus.mem_out = ram[bus.mem_adr];

  always @(posedge clk) begin
    if (bd_init) begin
      for (int i = 0; i < 16384; i++) ram[i] = pat(i);
    end else if (bd_we) begin
      ram[bd_adr] = bd_data;
    end
    if (bus.mem_load) ram[bus.mem_adr] = bus.mem_data;
  end

  // Per-cycle compare against the expected cycle stream; idle when empty.
  initial begin
    exp_t e;
    logic idle;
    logic ok;
    forever begin
      @(negedge clk);
      idle = (exq.size() == 0);
      if (idle) e = '0;
      else      e = exq.pop_front();
      ok = (bus.busy === e.busy) && (bus.done === e.done) && (bus.mem_load === e.load);
      if (e.busy && bus.mem_adr !== e.adr) ok = 1'b0;
      if (e.load && bus.mem_data !== e.data) ok = 1'b0;
      if (idle && (bus.mem_adr !== '0 || bus.mem_data !== '0)) ok = 1'b0;
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL bus_cycle t=%0t: got busy=%b done=%b load=%b adr=%0d data=%h, expected busy=%b done=%b load=%b adr=%0d data=%h",
                 $time, bus.busy, bus.done, bus.mem_load, bus.mem_adr, bus.mem_data,
                 e.busy, e.done, e.load, e.adr, e.data);
      end
      if (bus.done)     done_cnt++;
      if (bus.busy)     busy_cnt++;
      if (bus.mem_load) load_cnt++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic bd_write(input logic [ADR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_adr = a; bd_data = d;
    @(posedge clk);
    #1 bd_we = 1'b0;
    model_mem[a] = d;
  endtask

  // Expand one request into the cycles it must produce, following the
  // transfer rules word by word on a scratch copy of memory so that
  // overlapping copies see their own earlier writes.
  task automatic push_xfer(input logic m, input logic [ADR_W-1:0] s0, input logic [ADR_W-1:0] d0,
                           input int n, input logic [DATA_W-1:0] fv);
    logic [ADR_W-1:0]  s;
    logic [ADR_W-1:0]  d;
    logic [DATA_W-1:0] v;
    exp_t e;
    wr_t  w;
    s = s0; d = d0;
    tmp_mem = model_mem;
    wq.delete();
    for (int i = 0; i < n; i++) begin
      if (m == MODE_COPY) begin
        e = '0; e.busy = 1'b1; e.adr = s;
        exq.push_back(e);
        v = tmp_mem[s];
        s = s + 1'b1;
      end else begin
        v = fv;
      end
      e = '0; e.busy = 1'b1; e.load = 1'b1; e.adr = d; e.data = v;
      exq.push_back(e);
      tmp_mem[d] = v;
      w.adr = d; w.data = v;
      wq.push_back(w);
      d = d + 1'b1;
    end
    e = '0; e.done = 1'b1;
    exq.push_back(e);
  endtask

  task automatic start_xfer(input logic m, input logic [ADR_W-1:0] s, input logic [ADR_W-1:0] d,
                            input int n, input logic [DATA_W-1:0] fv);
    @(negedge clk);
    #1;
    done_cnt = 0; busy_cnt = 0; load_cnt = 0;
    bus.mode = m; bus.src = s; bus.dst = d; bus.len = LEN_W'(n); bus.fill_value = fv;
    bus.start = 1'b1;
    push_xfer(m, s, d, n, fv);
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.src = $urandom; bus.dst = $urandom; bus.len = $urandom; bus.mode = $urandom;
    bus.fill_value = $urandom;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (exq.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exq.size() != 0) begin
      checks++; errors++;
      $display("FAIL wait_idle: %0d cycles left pending, expected 0", exq.size());
      exq.delete();
    end
  endtask

  task automatic apply_writes(input int count);
    for (int i = 0; i < count && i < wq.size(); i++) model_mem[wq[i].adr] = wq[i].data;
  endtask

  task automatic mem_check(input string name);
    int bad;
    int first;
    bad = 0; first = -1;
    for (int i = 0; i < 16384; i++) begin
      if (ram[i] !== model_mem[i]) begin
        if (first < 0) first = i;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d words differ, first at %0d got %h expected %h",
               name, bad, first, ram[first], model_mem[first]);
    end
  endtask

  task automatic run_xfer(input string name, input logic m, input logic [ADR_W-1:0] s,
                          input logic [ADR_W-1:0] d, input int n, input logic [DATA_W-1:0] fv);
    start_xfer(m, s, d, n, fv);
    wait_idle(2 * n + 20);
    apply_writes(wq.size());
    mem_check(name);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; errors = 0; done_cnt = 0; busy_cnt = 0; load_cnt = 0;
    bd_init = 1'b0; bd_we = 1'b0; bd_adr = '0; bd_data = '0;
    bus.start = 1'b0; bus.mode = 1'b0; bus.src = '0; bus.dst = '0;
    bus.len = '0; bus.fill_value = '0;
    rst_n = 1'b0;

    for (int i = 0; i < 16384; i++) model_mem[i] = pat(i);
    @(negedge clk);
    bd_init = 1'b1;
    @(posedge clk);
    #1 bd_init = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 32'(bus.busy), 0);
    chk("reset_load", 32'(bus.mem_load), 0);
    #1 rst_n = 1'b1;

    // Copy of four words.
    for (int i = 0; i < 4; i++) bd_write(ADR_W'(100 + i), 16'hA000 + 16'(i));
    run_xfer("copy4_mem", MODE_COPY, 14'd100, 14'd200, 4, 16'h0000);
    chk("copy4_busy_cycles", 32'(busy_cnt), 8);
    chk("copy4_done_pulses", 32'(done_cnt), 1);
    chk("copy4_loads", 32'(load_cnt), 4);
    for (int i = 0; i < 4; i++) begin
      chk("copy4_dst_word", 32'(ram[200 + i]), 32'h0000A000 + 32'(i));
      chk("copy4_src_word", 32'(ram[100 + i]), 32'h0000A000 + 32'(i));
    end

    // Fill across the top of the address space.
    run_xfer("fill_wrap_mem", MODE_FILL, 14'd0, 14'd16382, 4, 16'h5A5A);
    chk("fill_wrap_16382", 32'(ram[16382]), 32'h5A5A);
    chk("fill_wrap_16383", 32'(ram[16383]), 32'h5A5A);
    chk("fill_wrap_0", 32'(ram[0]), 32'h5A5A);
    chk("fill_wrap_1", 32'(ram[1]), 32'h5A5A);
    chk("fill_wrap_ram4_untouched", 32'(ram[4]), 32'h5A9B);
    chk("fill_wrap_busy_cycles", 32'(busy_cnt), 4);
    chk("fill_wrap_done_pulses", 32'(done_cnt), 1);

    // Zero-length request.
    run_xfer("len0_mem", MODE_COPY, 14'd5, 14'd6, 0, 16'h0000);
    chk("len0_loads", 32'(load_cnt), 0);
    chk("len0_busy", 32'(busy_cnt), 0);
    chk("len0_done_pulses", 32'(done_cnt), 1);

    // Start held and parameters changed throughout an 8-word copy.
    start_xfer(MODE_COPY, 14'd1000, 14'd2000, 8, 16'h0000);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (exq.size() == 0) break;
      bus.start = 1'b1;
      bus.mode = $urandom; bus.src = $urandom; bus.dst = $urandom;
      bus.len = LEN_W'($urandom_range(1, 30)); bus.fill_value = $urandom;
    end
    bus.start = 1'b0;
    wait_idle(40);
    repeat (4) @(negedge clk);
    #1;
    apply_writes(wq.size());
    mem_check("restart_spam_mem");
    chk("restart_spam_done_pulses", 32'(done_cnt), 1);
    chk("restart_spam_busy_cycles", 32'(busy_cnt), 16);

    // Asynchronous reset in the middle of the third write of a 5-word fill.
    start_xfer(MODE_FILL, 14'd0, 14'd300, 5, 16'h1234);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    exq.delete();
    #1;
    chk("abort_load_async", 32'(bus.mem_load), 0);
    chk("abort_busy_async", 32'(bus.busy), 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    apply_writes(2);
    repeat (2) @(negedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt), 0);
    chk("abort_word0", 32'(ram[300]), 32'h1234);
    chk("abort_word1", 32'(ram[301]), 32'h1234);
    chk("abort_word2_untouched", 32'(ram[302]), 32'h71A9);
    mem_check("abort_mem");
    run_xfer("after_abort_mem", MODE_FILL, 14'd0, 14'd400, 3, 16'hBEEF);
    chk("after_abort_done", 32'(done_cnt), 1);

    // Overlapping ascending copy propagates the first word.
    for (int i = 0; i < 4; i++) bd_write(ADR_W'(10 + i), 16'(i + 1));
    run_xfer("overlap_mem", MODE_COPY, 14'd10, 14'd11, 3, 16'h0000);
    chk("overlap_11", 32'(ram[11]), 1);
    chk("overlap_12", 32'(ram[12]), 1);
    chk("overlap_13", 32'(ram[13]), 1);

    // Randomized transfers, some near the wrap point.
    for (int t = 0; t < 16; t++) begin
      logic              m;
      logic [ADR_W-1:0]  s;
      logic [ADR_W-1:0]  d;
      int                n;
      m = 1'($urandom);
      s = (t % 4 == 0) ? ADR_W'($urandom_range(16370, 16383)) : ADR_W'($urandom);
      d = (t % 3 == 0) ? ADR_W'($urandom_range(16370, 16383)) : ADR_W'($urandom);
      n = (t % 5 == 0) ? 0 : $urandom_range(1, 40);
      run_xfer("random_mem", m, s, d, n, 16'($urandom));
      chk("random_done_pulses", 32'(done_cnt), 1);
    end

    repeat (3) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
